// File: rtl/button_gpio_in_if.sv
// Signal bundle between the button conditioner and its GPIO-side consumer.
// The consumer drives pins/clears/mask; the conditioner returns levels, pulses and status.
interface button_gpio_in_if #(
   parameter int NUM_BUTTONS = 2
);
   logic [NUM_BUTTONS-1:0] io_buttons;
   logic [NUM_BUTTONS-1:0] io_flagClear;
   logic [NUM_BUTTONS-1:0] io_irqMask;
   logic [NUM_BUTTONS-1:0] io_level;
   logic [NUM_BUTTONS-1:0] io_pressPulse;
   logic [NUM_BUTTONS-1:0] io_releasePulse;
   logic [NUM_BUTTONS-1:0] io_pressFlag;
   logic [31:0]            io_gpioRead;
   logic                   io_irq;

   modport master (
      output io_buttons, io_flagClear, io_irqMask,
      input  io_level, io_pressPulse, io_releasePulse, io_pressFlag, io_gpioRead, io_irq
   );

   modport slave (
      input  io_buttons, io_flagClear, io_irqMask,
      output io_level, io_pressPulse, io_releasePulse, io_pressFlag, io_gpioRead, io_irq
   );
endinterface

// File: rtl/button_gpio_in.sv
// Push-button conditioner: 2-flop sync, per-button stability debounce, press/release
// pulses, sticky press flags with clear, packed GPIO read word and maskable interrupt.
module button_gpio_in #(
   parameter int NUM_BUTTONS     = 2,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic              io_mainClk,
   input  logic              io_asyncResetN,
   button_gpio_in_if.slave   bus
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_BUTTONS-1:0] PIN_IDLE = (ACTIVE_LOW != 0) ? {NUM_BUTTONS{1'b1}}
                                                                   : {NUM_BUTTONS{1'b0}};

   logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
   logic [NUM_BUTTONS-1:0] s;
   logic [NUM_BUTTONS-1:0] level_q, level_d;
   logic [NUM_BUTTONS-1:0] level_dly_q;
   logic [NUM_BUTTONS-1:0] press_q, press_d;
   logic [NUM_BUTTONS-1:0] release_q, release_d;
   logic [NUM_BUTTONS-1:0] flag_q, flag_d;
   logic [CW-1:0]          cnt_q [NUM_BUTTONS];
   logic [CW-1:0]          cnt_d [NUM_BUTTONS];

   assign s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

   always_comb begin
      level_d = level_q;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         cnt_d[i] = '0;
         if (s[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               level_d[i] = s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   assign press_d   =  level_q & ~level_dly_q;
   assign release_d = ~level_q &  level_dly_q;

   // Set wins over clear both on the edge that raises the pulse and while it is visible.
   assign flag_d = press_d | (flag_q & ~(bus.io_flagClear & ~press_q));

   always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
      if (!io_asyncResetN) begin
         sync1_q     <= PIN_IDLE;
         sync2_q     <= PIN_IDLE;
         level_q     <= '0;
         level_dly_q <= '0;
         press_q     <= '0;
         release_q   <= '0;
         flag_q      <= '0;
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q     <= bus.io_buttons;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         press_q     <= press_d;
         release_q   <= release_d;
         flag_q      <= flag_d;
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      bus.io_gpioRead = '0;
      bus.io_gpioRead[NUM_BUTTONS-1:0]   = level_q;
      bus.io_gpioRead[8 +: NUM_BUTTONS]  = flag_q;
   end

   assign bus.io_level        = level_q;
   assign bus.io_pressPulse   = press_q;
   assign bus.io_releasePulse = release_q;
   assign bus.io_pressFlag    = flag_q;
   assign bus.io_irq          = |(flag_q & bus.io_irqMask);

endmodule
